// File: rtl/trigger_capture_if.sv
// rtl/trigger_capture_if.sv - sample stream in and buffer readout bundle for trigger_capture
interface trigger_capture_if #(
  parameter int BITS_ADC = 8
);
  logic [BITS_ADC-1:0] sample_in;
  logic                rdy_in;
  logic                rd_en;
  logic [BITS_ADC-1:0] rd_data;
  logic                rd_valid;

  modport master (
    output sample_in, rdy_in, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample_in, rdy_in, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - level/edge trigger with pre/post window captured in a circular RAM
module trigger_capture #(
  parameter int BITS_ADC = 8,
  parameter int BUF_ADDR = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                force_trig,
  input  logic [BITS_ADC-1:0] trig_level,
  input  logic                trig_edge,
  input  logic [BUF_ADDR-1:0] pretrig_len,
  trigger_capture_if.slave    bus,
  output logic                busy,
  output logic                triggered,
  output logic                done
);
  localparam int DEPTH = 2 ** BUF_ADDR;
  localparam logic [BUF_ADDR-1:0] ONE = BUF_ADDR'(1);

  typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} state_t;

  state_t              state_q, state_d;
  logic [BUF_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_ADDR-1:0] cnt_q, cnt_d;
  logic [BUF_ADDR-1:0] pl_q, pl_d;
  logic [BUF_ADDR-1:0] trig_addr_q, trig_addr_d;
  logic [BITS_ADC-1:0] prev_q, prev_d;
  logic [BITS_ADC-1:0] rd_data_q, rd_data_d;
  logic                prev_valid_q, prev_valid_d;
  logic                force_pend_q, force_pend_d;
  logic                triggered_q, triggered_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BITS_ADC-1:0] mem [DEPTH];
  logic                wr_en;
  logic                edge_hit;
  logic                trig_hit;
  logic [BUF_ADDR-1:0] post_len;

  // DEPTH-1-pl in BUF_ADDR bits is simply the bitwise complement of pl.
  assign post_len = ~pl_q;

  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid_q) begin
      if (trig_edge)
        edge_hit = (prev_q > trig_level) && (bus.sample_in <= trig_level);
      else
        edge_hit = (prev_q < trig_level) && (bus.sample_in >= trig_level);
    end
    trig_hit = force_pend_q || force_trig || edge_hit;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    pl_d         = pl_q;
    trig_addr_d  = trig_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    triggered_d  = triggered_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_en        = 1'b0;

    if (state_q == DONE && bus.rd_en) begin
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + ONE;
    end

    if ((state_q inside {PRETRIG, WAIT_TRIG, POSTTRIG}) && bus.rdy_in) begin
      wr_en        = 1'b1;
      wr_ptr_d     = wr_ptr_q + ONE;
      prev_d       = bus.sample_in;
      prev_valid_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = PRETRIG;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
          triggered_d  = 1'b0;
          force_pend_d = 1'b0;
          // The port width already caps the request at DEPTH-1.
          pl_d         = pretrig_len;
        end
      end
      PRETRIG: begin
        if (pl_q == '0) begin
          state_d = WAIT_TRIG;
        end else if (bus.rdy_in) begin
          if (cnt_q + ONE == pl_q) begin
            state_d = WAIT_TRIG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      WAIT_TRIG: begin
        if (bus.rdy_in && trig_hit) begin
          trig_addr_d  = wr_ptr_q;
          triggered_d  = 1'b1;
          force_pend_d = 1'b0;
          cnt_d        = '0;
          if (post_len == '0) begin
            state_d  = DONE;
            rd_ptr_d = wr_ptr_q - pl_q;
          end else begin
            state_d = POSTTRIG;
          end
        end else if (force_trig) begin
          force_pend_d = 1'b1;
        end
      end
      POSTTRIG: begin
        if (bus.rdy_in) begin
          if (cnt_q + ONE == post_len) begin
            state_d  = DONE;
            rd_ptr_d = trig_addr_q - pl_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = state_d inside {PRETRIG, WAIT_TRIG, POSTTRIG};
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pl_q         <= '0;
      trig_addr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pl_q         <= pl_d;
      trig_addr_q  <= trig_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      triggered_q  <= triggered_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Sample storage is left uninitialised so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.sample_in;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign busy         = busy_q;
  assign triggered    = triggered_q;
  assign done         = done_q;
endmodule
